// File: rtl/int_iq_pkg.sv
// Shared widths, field offsets and the default-width entry layout for the integer issue queue.
// Entry layout, LSB first: src1_rdy, src1_tag, src2_rdy, src2_tag, dst_tag, payload.
package int_iq_pkg;

  localparam int TAG_W_DEF     = 6;
  localparam int PAYLOAD_W_DEF = 32;

  localparam int OFF_SRC1_RDY = 0;
  localparam int OFF_SRC1_TAG = 1;

  function automatic int off_src2_rdy(input int tag_w);
    return tag_w + 1;
  endfunction

  function automatic int off_src2_tag(input int tag_w);
    return tag_w + 2;
  endfunction

  function automatic int off_dst_tag(input int tag_w);
    return 2 * tag_w + 2;
  endfunction

  function automatic int off_payload(input int tag_w);
    return 3 * tag_w + 2;
  endfunction

  function automatic int entry_w(input int tag_w, input int payload_w);
    return payload_w + 3 * tag_w + 2;
  endfunction

  function automatic int issue_w(input int tag_w, input int payload_w);
    return payload_w + 3 * tag_w;
  endfunction

  typedef struct packed {
    logic [PAYLOAD_W_DEF-1:0] payload;
    logic [TAG_W_DEF-1:0]     dst_tag;
    logic [TAG_W_DEF-1:0]     src2_tag;
    logic                     src2_rdy;
    logic [TAG_W_DEF-1:0]     src1_tag;
    logic                     src1_rdy;
  } iiq_entry_t;

endpackage

// File: rtl/iq_wakeup_cam.sv
// Compares both source tags of one entry against every wakeup broadcast channel.
module iq_wakeup_cam #(
  parameter int TAG_W      = 6,
  parameter int NUM_WAKEUP = 2
) (
  input  logic [TAG_W-1:0]            src1_tag,
  input  logic [TAG_W-1:0]            src2_tag,
  input  logic [NUM_WAKEUP-1:0]       wakeup_valid,
  input  logic [NUM_WAKEUP*TAG_W-1:0] wakeup_tag,
  output logic                        src1_match,
  output logic                        src2_match
);

  logic [NUM_WAKEUP-1:0] hit1;
  logic [NUM_WAKEUP-1:0] hit2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAKEUP; gi++) begin : g_chan
      assign hit1[gi] = wakeup_valid[gi] && (wakeup_tag[gi*TAG_W +: TAG_W] == src1_tag);
      assign hit2[gi] = wakeup_valid[gi] && (wakeup_tag[gi*TAG_W +: TAG_W] == src2_tag);
    end
  endgenerate

  assign src1_match = |hit1;
  assign src2_match = |hit2;

endmodule

// File: rtl/int_issue_queue_param.sv
// Age-ordered collapsing integer issue queue: oldest fully-ready entry issues,
// younger entries shift down, operands wake from tag broadcasts.
module int_issue_queue_param
  import int_iq_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int PAYLOAD_W  = PAYLOAD_W_DEF,
  parameter int NUM_WAKEUP = 2,
  localparam int ENTRY_W   = entry_w(TAG_W, PAYLOAD_W),
  localparam int ISSUE_W   = issue_w(TAG_W, PAYLOAD_W),
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_aL,
  input  logic                        flush,
  output logic                        dispatch_ready,
  input  logic                        dispatch_valid,
  input  logic [ENTRY_W-1:0]          dispatch_data,
  input  logic [NUM_WAKEUP-1:0]       wakeup_valid,
  input  logic [NUM_WAKEUP*TAG_W-1:0] wakeup_tag,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [ISSUE_W-1:0]          issue_data,
  output logic [OCC_W-1:0]            occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int O_S1R = OFF_SRC1_RDY;
  localparam int O_S1T = OFF_SRC1_TAG;
  localparam int O_S2R = off_src2_rdy(TAG_W);
  localparam int O_S2T = off_src2_tag(TAG_W);

  logic [ENTRY_W-1:0] entry_reg  [DEPTH];
  logic [ENTRY_W-1:0] entry_next [DEPTH];
  // Index DEPTH of cam_in/upd is the incoming dispatch entry snooping the bus.
  logic [ENTRY_W-1:0] cam_in     [DEPTH+1];
  logic [ENTRY_W-1:0] upd        [DEPTH+1];
  logic [OCC_W-1:0]   occ_reg;
  logic [OCC_W-1:0]   occ_next;
  logic [OCC_W-1:0]   wr_slot;
  logic [DEPTH-1:0]   rdy_vec;
  logic [IDX_W-1:0]   sel_idx;
  logic               issue_fire;
  logic               disp_fire;

  genvar gi;
  generate
    for (gi = 0; gi <= DEPTH; gi++) begin : g_cam
      logic m1;
      logic m2;
      if (gi < DEPTH) begin : g_ent
        assign cam_in[gi] = entry_reg[gi];
      end else begin : g_disp
        assign cam_in[gi] = dispatch_data;
      end
      iq_wakeup_cam #(
        .TAG_W      (TAG_W),
        .NUM_WAKEUP (NUM_WAKEUP)
      ) u_cam (
        .src1_tag     (cam_in[gi][O_S1T +: TAG_W]),
        .src2_tag     (cam_in[gi][O_S2T +: TAG_W]),
        .wakeup_valid (wakeup_valid),
        .wakeup_tag   (wakeup_tag),
        .src1_match   (m1),
        .src2_match   (m2)
      );
      assign upd[gi] = cam_in[gi] | (ENTRY_W'(m2) << O_S2R) | (ENTRY_W'(m1) << O_S1R);
    end

    // Eligibility uses registered readiness, giving one cycle wakeup-to-issue.
    for (gi = 0; gi < DEPTH; gi++) begin : g_rdy
      assign rdy_vec[gi] = (OCC_W'(gi) < occ_reg) && entry_reg[gi][O_S1R] && entry_reg[gi][O_S2R];
    end
  endgenerate

  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy_vec[i]) sel_idx = IDX_W'(i);
    end
  end

  assign issue_valid    = (|rdy_vec) && !flush;
  assign issue_fire     = issue_valid && issue_ready;
  assign dispatch_ready = occ_reg < OCC_W'(DEPTH);
  assign disp_fire      = dispatch_valid && dispatch_ready && !flush;
  assign wr_slot        = occ_reg - OCC_W'(issue_fire);
  assign occupancy      = occ_reg;
  assign issue_data     = issue_valid ?
                          {entry_reg[sel_idx][ENTRY_W-1:O_S2T], entry_reg[sel_idx][O_S1T +: TAG_W]} :
                          '0;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && i >= int'(sel_idx)) entry_next[i] = upd[i+1];
      else                                   entry_next[i] = upd[i];
      if (disp_fire && OCC_W'(i) == wr_slot) entry_next[i] = upd[DEPTH];
    end
  end

  assign occ_next = flush ? '0 : occ_reg + OCC_W'(disp_fire) - OCC_W'(issue_fire);

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      occ_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      occ_reg <= occ_next;
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
    end
  end

endmodule
